rom_char_arbiter: RTL and testbench



---
 rtl/rom_char_arbiter_if.sv | 28 ++
 rtl/rom_char_arbiter.sv | 103 ++++++++++
 tb/tb_rom_char_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_char_arbiter_if.sv
// Requester-side bundle for one port of the character-ROM arbiter.
// Request handshake and the response pulse share one interface.
interface rom_char_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  ready;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output valid,
        output addr,
        input  ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  valid,
        input  addr,
        output ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/rom_char_arbiter.sv
// Round-robin arbiter sharing the single-port font ROM between two overlay
// engines; a {valid,id} tag pipeline steers each returned word to its issuer.
module rom_char_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    rom_char_arbiter_if.slave     req0,
    rom_char_arbiter_if.slave     req1,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_clk_en,
    input  logic [DATA_WIDTH-1:0] rom_rd_data,
    output logic                  busy
);

    logic                  grant0;
    logic                  grant1;
    logic                  last_grant;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [RD_LATENCY-1:0] stg_valid;
    logic [RD_LATENCY-1:0] stg_id;
    logic                  rsp0_valid_q;
    logic                  rsp1_valid_q;
    logic [DATA_WIDTH-1:0] rsp0_data_q;
    logic [DATA_WIDTH-1:0] rsp1_data_q;
    logic                  active;

    // last_grant==1 means requester 0 wins the next contention
    always_comb begin
        grant0 = !rst && en && req0.valid && (!req1.valid || last_grant);
        grant1 = !rst && en && req1.valid && (!req0.valid || !last_grant);
    end

    assign req0.ready = grant0;
    assign req1.ready = grant1;

    always_comb begin
        rom_addr = addr_q;
        if (rst)
            rom_addr = '0;
        else if (grant0)
            rom_addr = req0.addr;
        else if (grant1)
            rom_addr = req1.addr;
    end

    assign active     = !rst && (grant0 || grant1 || (|stg_valid));
    assign rom_clk_en = active;
    assign busy       = active;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            addr_q     <= '0;
        end else if (grant0) begin
            last_grant <= 1'b0;
            addr_q     <= req0.addr;
        end else if (grant1) begin
            last_grant <= 1'b1;
            addr_q     <= req1.addr;
        end
    end

    // Tag pipeline mirrors the ROM read latency; the last stage qualifies rom_rd_data
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid <= '0;
            stg_id    <= '0;
        end else begin
            stg_valid[0] <= grant0 || grant1;
            stg_id[0]    <= grant1;
            for (int i = 1; i < RD_LATENCY; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_id[i]    <= stg_id[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            rsp0_valid_q <= stg_valid[RD_LATENCY-1] && !stg_id[RD_LATENCY-1];
            rsp1_valid_q <= stg_valid[RD_LATENCY-1] &&  stg_id[RD_LATENCY-1];
            if (stg_valid[RD_LATENCY-1] && !stg_id[RD_LATENCY-1])
                rsp0_data_q <= rom_rd_data;
            if (stg_valid[RD_LATENCY-1] && stg_id[RD_LATENCY-1])
                rsp1_data_q <= rom_rd_data;
        end
    end

    assign req0.rsp_valid = rsp0_valid_q;
    assign req0.rsp_data  = rsp0_data_q;
    assign req1.rsp_valid = rsp1_valid_q;
    assign req1.rsp_data  = rsp1_data_q;

endmodule

// File: tb/tb_rom_char_arbiter.sv
// Directed bench for rom_char_arbiter: three instances (RD_LATENCY 1, 2, 4)
// share one stimulus; the latency-2 instance is scoreboarded every cycle.
module tb_rom_char_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NC = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          req0_valid;
    logic          req1_valid;
    logic [AW-1:0] req0_addr;
    logic [AW-1:0] req1_addr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit sb_on  = 1'b0;

    logic          rdy0 [3];
    logic          rdy1 [3];
    logic          rv0  [3];
    logic          rv1  [3];
    logic          cen  [3];
    logic          bsy  [3];
    logic [DW-1:0] rd0  [3];
    logic [DW-1:0] rd1  [3];
    logic [AW-1:0] raddr[3];

    logic          ev0 [NC];
    logic          ev1 [NC];
    logic [DW-1:0] ed0 [NC];
    logic [DW-1:0] ed1 [NC];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {6'h2A, a, 6'h15, ~a};
    endfunction

    for (genvar k = 0; k < 3; k++) begin : lat
        localparam int L = (k == 0) ? 1 : (k == 1) ? 2 : 4;
        rom_char_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p0 ();
        rom_char_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p1 ();
        logic [AW-1:0] rom_addr;
        logic          rom_clk_en;
        logic          busy;
        logic [DW-1:0] rom_rd_data;
        logic [DW-1:0] pipe [4];

        assign p0.valid = req0_valid;
        assign p0.addr  = req0_addr;
        assign p1.valid = req1_valid;
        assign p1.addr  = req1_addr;

        // ROM model: address sampled on an enabled edge, data after L edges
        always @(posedge clk) begin
            if (rom_clk_en) begin
                pipe[0] <= rom_word(rom_addr);
                for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign rom_rd_data = pipe[L-1];

        rom_char_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L)) dut (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .req0       (p0),
            .req1       (p1),
            .rom_addr   (rom_addr),
            .rom_clk_en (rom_clk_en),
            .rom_rd_data(rom_rd_data),
            .busy       (busy)
        );

        assign rdy0[k]  = p0.ready;
        assign rdy1[k]  = p1.ready;
        assign rv0[k]   = p0.rsp_valid;
        assign rv1[k]   = p1.rsp_valid;
        assign rd0[k]   = p0.rsp_data;
        assign rd1[k]   = p1.rsp_data;
        assign raddr[k] = rom_addr;
        assign cen[k]   = rom_clk_en;
        assign bsy[k]   = busy;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Latency-2 instance responds 3 cycles after the accepting cycle
    task automatic expect_rsp(input int port, input logic [AW-1:0] a);
        int t;
        t = cyc + 3;
        if (port == 0) begin
            ev0[t] = 1'b1;
            ed0[t] = rom_word(a);
        end else begin
            ev1[t] = 1'b1;
            ed1[t] = rom_word(a);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (sb_on) begin
                chk("rsp0_valid", rv0[1], ev0[cyc]);
                if (ev0[cyc]) chk("rsp0_data", rd0[1], ed0[cyc]);
                chk("rsp1_valid", rv1[1], ev1[cyc]);
                if (ev1[cyc]) chk("rsp1_data", rd1[1], ed1[cyc]);
            end
        end
    end

    initial begin
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        int            port;
        int            lt;

        for (int i = 0; i < NC; i++) begin
            ev0[i] = 1'b0;
            ev1[i] = 1'b0;
            ed0[i] = '0;
            ed1[i] = '0;
        end

        // Reset with both requesters asserting: nothing may be granted
        rst = 1'b1; en = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_addr = 10'h3FF; req1_addr = 10'h2AA;
        repeat (2) tick;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready0", rdy0[k], 1'b0);
            chk("rst_ready1", rdy1[k], 1'b0);
            chk("rst_rom_addr", raddr[k], 10'h000);
            chk("rst_clk_en", cen[k], 1'b0);
            chk("rst_busy", bsy[k], 1'b0);
        end

        tick;
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("post_rst_rsp0_data", rd0[1], 32'h0);
        chk("post_rst_rsp1_data", rd1[1], 32'h0);
        sb_on = 1'b1;

        // Single request, checked on all latencies
        tick;
        req0_valid = 1'b1; req0_addr = 10'h041;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("single_ready0", rdy0[k], 1'b1);
            chk("single_ready1", rdy1[k], 1'b0);
            chk("single_rom_addr", raddr[k], 10'h041);
            chk("single_clk_en", cen[k], 1'b1);
        end
        expect_rsp(0, 10'h041);
        for (int d = 1; d <= 6; d++) begin
            tick;
            req0_valid = 1'b0;
            #1;
            for (int k = 0; k < 3; k += 2) begin
                lt = (k == 0) ? 1 : 4;
                chk("sweep_rsp0_valid", rv0[k], (d == lt + 1));
                chk("sweep_rsp1_valid", rv1[k], 1'b0);
                if (d == lt + 1) chk("sweep_rsp0_data", rd0[k], rom_word(10'h041));
            end
        end

        // Back-to-back streaming on requester 1
        for (int i = 0; i < 16; i++) begin
            tick;
            req1_valid = 1'b1; req1_addr = 10'h100 + 10'(i);
            #1;
            chk("stream_ready1", rdy1[1], 1'b1);
            chk("stream_rom_addr", raddr[1], 10'h100 + 10'(i));
            chk("stream_busy", bsy[1], 1'b1);
            expect_rsp(1, 10'h100 + 10'(i));
        end
        tick; req1_valid = 1'b0; #1;
        chk("stream_busy_tail1", bsy[1], 1'b1);
        tick; #1;
        chk("stream_busy_tail2", bsy[1], 1'b1);
        tick; #1;
        chk("stream_busy_low", bsy[1], 1'b0);
        chk("stream_clk_en_low", cen[1], 1'b0);
        repeat (2) tick;

        // Enable gating with an idle pipeline
        for (int i = 0; i < 3; i++) begin
            tick;
            en = 1'b0;
            req0_valid = 1'b1; req0_addr = 10'h0AA;
            req1_valid = 1'b1; req1_addr = 10'h0BB;
            #1;
            chk("gate_ready0", rdy0[1], 1'b0);
            chk("gate_ready1", rdy1[1], 1'b0);
            chk("gate_rom_addr", raddr[1], 10'h10F);
            chk("gate_clk_en", cen[1], 1'b0);
        end
        tick; en = 1'b1; #1;
        chk("resume_ready0", rdy0[1], 1'b1);
        chk("resume_ready1", rdy1[1], 1'b0);
        chk("resume_rom_addr", raddr[1], 10'h0AA);
        expect_rsp(0, 10'h0AA);
        tick; req0_addr = 10'h0AC; #1;
        chk("resume2_ready0", rdy0[1], 1'b0);
        chk("resume2_ready1", rdy1[1], 1'b1);
        chk("resume2_rom_addr", raddr[1], 10'h0BB);
        expect_rsp(1, 10'h0BB);
        tick; en = 1'b0; #1;
        chk("gate_inflight_ready0", rdy0[1], 1'b0);
        chk("gate_inflight_ready1", rdy1[1], 1'b0);
        chk("gate_inflight_rom_addr", raddr[1], 10'h0BB);
        chk("gate_inflight_clk_en", cen[1], 1'b1);
        tick; req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) tick;

        // Reset one cycle after a grant drops that read
        tick; en = 1'b1; req0_valid = 1'b1; req0_addr = 10'h055; #1;
        chk("midrst_ready0", rdy0[1], 1'b1);
        tick; rst = 1'b1; req0_valid = 1'b0; #1;
        chk("midrst_rom_addr", raddr[1], 10'h000);
        chk("midrst_clk_en", cen[1], 1'b0);
        chk("midrst_busy", bsy[1], 1'b0);
        tick; rst = 1'b0; #1;
        chk("after_rst_rsp0_valid", rv0[1], 1'b0);
        chk("after_rst_rsp1_valid", rv1[1], 1'b0);
        chk("after_rst_rsp0_data", rd0[1], 32'h0);
        chk("after_rst_rsp1_data", rd1[1], 32'h0);
        chk("after_rst_rom_addr", raddr[1], 10'h000);
        chk("after_rst_busy", bsy[1], 1'b0);

        // Contention after reset: requester 0 first, then alternate
        a0 = 10'h010; a1 = 10'h020;
        for (int i = 0; i < 4; i++) begin
            tick;
            req0_valid = 1'b1; req0_addr = a0;
            req1_valid = 1'b1; req1_addr = a1;
            #1;
            port = i % 2;
            chk("rr_ready0", rdy0[1], (port == 0));
            chk("rr_ready1", rdy1[1], (port == 1));
            chk("rr_rom_addr", raddr[1], (port == 0) ? a0 : a1);
            if (port == 0) begin
                expect_rsp(0, a0);
                a0 = a0 + 10'd1;
            end else begin
                expect_rsp(1, a1);
                a1 = a1 + 10'd1;
            end
        end
        tick; req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (5) tick;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
